ula_arbitro: RTL and testbench

- Shares one 16-bit ULA (add when sel=0, multiply when sel=1, overflow flag for add) between two requesters.
- Round-robin arbitration; registered operand issue; one result buffered and returned with a requester tag over a valid/ready response channel.
- Sits between two datapath clients and the single ULA instance. Also keeps a completed-operation counter.

---
 rtl/ula_arbitro.sv | 116 +++++++++++
 tb/tb_ula_arbitro.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter sharing one ULA (add/multiply) between two requesters.
// Optional feature macro ULA_SATURA_EN: saturate overflowing add results instead of wrapping.
module ula_arbitro #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic             req_sel0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic             req_sel1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_c,
   output logic             rsp_ovf,
   output logic [WIDTH-1:0] ula_a,
   output logic [WIDTH-1:0] ula_b,
   output logic             ula_sel,
   input  logic [WIDTH-1:0] ula_c,
   input  logic             ula_ovf,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

   estado_t          estado, proximo;
   logic             last_grant;
   logic             grant_ok;
   logic             grant_id;
   logic             rsp_hs;
   logic [WIDTH-1:0] res_c;

   // Grants are only made while idle; a tie goes to the requester not served last.
   always_comb begin
      grant_ok = 1'b0;
      grant_id = 1'b0;
      if (estado == OCIOSO) begin
         case (req_valid)
            2'b01:   begin grant_ok = 1'b1; grant_id = 1'b0;        end
            2'b10:   begin grant_ok = 1'b1; grant_id = 1'b1;        end
            2'b11:   begin grant_ok = 1'b1; grant_id = ~last_grant; end
            default: ;
         endcase
      end
   end

   assign rsp_hs = rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= OCIOSO;
      else        estado <= proximo;
   end

   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO:   if (grant_ok) proximo = EXECUTA;
         EXECUTA:  proximo = RESPONDE;
         RESPONDE: if (rsp_hs) proximo = OCIOSO;
         default:  proximo = OCIOSO;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (grant_ok) req_ready[grant_id] = 1'b1;
      busy = (estado != OCIOSO);
   end

   always_comb begin
      res_c = ula_c;
`ifdef ULA_SATURA_EN
      // Clamp toward the sign of the operands (both share ula_a's sign on overflow).
      if (!ula_sel && ula_ovf)
         res_c = ula_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ula_a      <= '0;
         ula_b      <= '0;
         ula_sel    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_c      <= '0;
         rsp_ovf    <= 1'b0;
         op_count   <= '0;
         last_grant <= 1'b1;
      end else begin
         if (grant_ok) begin
            ula_a      <= grant_id ? req_a1   : req_a0;
            ula_b      <= grant_id ? req_b1   : req_b0;
            ula_sel    <= grant_id ? req_sel1 : req_sel0;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
         end
         if (estado == EXECUTA) begin
            rsp_c     <= res_c;
            rsp_ovf   <= ula_ovf & ~ula_sel;
            rsp_valid <= 1'b1;
         end else if (rsp_hs) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ula_arbitro.sv
// Self-checking bench for ula_arbitro: behavioural ULA, cycle model of the arbiter and a response scoreboard.
module tb_ula_arbitro;
   localparam int WIDTH = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid, req_ready;
   logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
   logic             req_sel0, req_sel1;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_ovf;
   logic [WIDTH-1:0] rsp_c, ula_a, ula_b, ula_c;
   logic             ula_sel, ula_ovf, busy;
   logic [CNT_W-1:0] op_count;
   logic [WIDTH-1:0] soma;
   logic [2*WIDTH-1:0] prod;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sel;
      logic [WIDTH-1:0] c;
      logic             ovf;
   } rsp_t;

   rsp_t fila[$];
   logic id_log[$];
   int   hs_cyc[$];
   int   m_st;
   logic m_last;
   logic [CNT_W-1:0] m_cnt;
   logic [1:0] pv, pacc;
   logic [WIDTH-1:0] pa0, pb0, pa1, pb1;
   logic ps0, ps1;

   ula_arbitro #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
      .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_c(rsp_c), .rsp_ovf(rsp_ovf),
      .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel),
      .ula_c(ula_c), .ula_ovf(ula_ovf),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ULA
   always_comb begin
      soma    = ula_a + ula_b;
      prod    = ula_a * ula_b;
      ula_c   = ula_sel ? prod[WIDTH-1:0] : soma;
      ula_ovf = (ula_a[WIDTH-1] == ula_b[WIDTH-1]) && (soma[WIDTH-1] != ula_a[WIDTH-1]);
   end

   function automatic logic [WIDTH:0] modelo_ula(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic sel);
      logic [WIDTH-1:0]   s;
      logic [2*WIDTH-1:0] p;
      logic               ov;
      s = a + b;
      p = a * b;
      if (sel) return {1'b0, p[WIDTH-1:0]};
      ov = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`ifdef ULA_SATURA_EN
      if (ov) s = a[WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif
      return {ov, s};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Cycle model + scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      logic [1:0] exp_rdy;
      rsp_t       e;
      if (!rst_n) begin
         fila.delete();
         m_st   = 0;
         m_last = 1'b1;
         m_cnt  = '0;
         pv     = '0;
         pacc   = '0;
      end else begin
         if (pv[0] && !pacc[0])
            chk("hold_req0", {req_valid[0], req_sel0, req_a0, req_b0}, {1'b1, ps0, pa0, pb0});
         if (pv[1] && !pacc[1])
            chk("hold_req1", {req_valid[1], req_sel1, req_a1, req_b1}, {1'b1, ps1, pa1, pb1});
         exp_rdy = '0;
         if (m_st == 0) begin
            case (req_valid)
               2'b01:   exp_rdy = 2'b01;
               2'b10:   exp_rdy = 2'b10;
               2'b11:   exp_rdy = m_last ? 2'b01 : 2'b10;
               default: exp_rdy = 2'b00;
            endcase
         end
         chk("req_ready", req_ready, exp_rdy);
         chk("busy", busy, m_st != 0);
         chk("rsp_valid", rsp_valid, m_st == 2);
         chk("op_count", op_count, m_cnt);
         case (m_st)
            0: if (exp_rdy != 2'b00) begin
                  e.id  = exp_rdy[1];
                  e.a   = e.id ? req_a1 : req_a0;
                  e.b   = e.id ? req_b1 : req_b0;
                  e.sel = e.id ? req_sel1 : req_sel0;
                  {e.ovf, e.c} = modelo_ula(e.a, e.b, e.sel);
                  fila.push_back(e);
                  m_last = e.id;
                  m_st   = 1;
               end
            1: begin
                  chk("ula_ops", {ula_sel, ula_a, ula_b}, {fila[0].sel, fila[0].a, fila[0].b});
                  m_st = 2;
               end
            default: begin
                  chk("sb_rsp", {rsp_id, rsp_ovf, rsp_c}, {fila[0].id, fila[0].ovf, fila[0].c});
                  if (rsp_ready) begin
                     void'(fila.pop_front());
                     m_cnt = m_cnt + CNT_W'(1);
                     id_log.push_back(rsp_id);
                     hs_cyc.push_back(cyc);
                     m_st = 0;
                  end
               end
         endcase
         pv   = req_valid;
         pacc = exp_rdy;
         pa0 = req_a0; pb0 = req_b0; ps0 = req_sel0;
         pa1 = req_a1; pb1 = req_b1; ps1 = req_sel1;
      end
   end

   // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic envia(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sel);
      int k = 0;
      if (i == 0) begin req_a0 = a; req_b0 = b; req_sel0 = sel; end
      else        begin req_a1 = a; req_b1 = b; req_sel1 = sel; end
      req_valid[i] = 1'b1;
      @(negedge clk);
      while (!req_ready[i] && k < 20) begin @(negedge clk); k++; end
      if (!req_ready[i]) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic espera_rsp(input string tag, input logic id, input logic [WIDTH-1:0] c, input logic ovf,
                             output int k);
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
      #1;
      chk({tag, "_valid"}, rsp_valid, 1'b1);
      chk({tag, "_id"}, rsp_id, id);
      chk({tag, "_c"}, rsp_c, c);
      chk({tag, "_ovf"}, rsp_ovf, ovf);
   endtask

   // Retire accepted requests once the response log reaches alvo entries.
   task automatic drena(input int alvo);
      logic [1:0] acc;
      for (int n = 0; n < 60 && req_valid != 2'b00; n++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk); #1;
         if (id_log.size() >= alvo) req_valid = req_valid & ~acc;
      end
      if (req_valid != 2'b00) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic espera_ocioso();
      int k = 0;
      @(negedge clk);
      while (busy && k < 20) begin @(negedge clk); k++; end
      if (busy) chk("idle_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int lat;
      int n0;
      logic [CNT_W-1:0] c0;
      rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 2'b00;
      req_a0 = '0; req_b0 = '0; req_sel0 = 1'b0;
      req_a1 = '0; req_b1 = '0; req_sel1 = 1'b0;
      #1;
      chk("rst_outputs", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_ovf, busy},
          {2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
      chk("rst_ula", {ula_sel, ula_a, ula_b}, '0);
      chk("rst_count", op_count, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // single add, latency and counter
      envia(0, 16'h0003, 16'h0004, 1'b0);
      espera_rsp("add_3_4", 1'b0, 16'h0007, 1'b0, lat);
      chk("latency", lat, 1);
      @(negedge clk); #1;
      chk("count_after_1", op_count, 16'h0001);
      @(posedge clk); #1;

      envia(1, 16'h0012, 16'h0003, 1'b1);
      espera_rsp("mul_12_3", 1'b1, 16'h0036, 1'b0, lat);
      espera_ocioso();

      // round robin with both requesters continuously valid
      n0 = id_log.size();
      req_a0 = 16'h0010; req_b0 = 16'h0020; req_sel0 = 1'b0;
      req_a1 = 16'h0005; req_b1 = 16'h0006; req_sel1 = 1'b1;
      req_valid = 2'b11;
      drena(n0 + 4);
      espera_ocioso();
      if (id_log.size() < n0 + 4) chk("rr_count", id_log.size(), n0 + 4);
      else begin
         chk("rr_id0", id_log[n0],   1'b0);
         chk("rr_id1", id_log[n0+1], 1'b1);
         chk("rr_id2", id_log[n0+2], 1'b0);
         chk("rr_id3", id_log[n0+3], 1'b1);
         for (int k = 0; k < 3; k++) chk("rr_gap", hs_cyc[n0+k+1] - hs_cyc[n0+k], 3);
      end

      // response back-pressure
      rsp_ready = 1'b0;
      envia(0, 16'h0005, 16'h0006, 1'b0);
      espera_rsp("bp", 1'b0, 16'h000B, 1'b0, lat);
      req_a1 = 16'h0007; req_b1 = 16'h0008; req_sel1 = 1'b1;
      req_valid[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("bp_hold", {rsp_valid, rsp_id, rsp_c, rsp_ovf}, {1'b1, 1'b0, 16'h000B, 1'b0});
         chk("bp_ready", {req_ready, busy}, {2'b00, 1'b1});
      end
      c0 = m_cnt;
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      chk("bp_done_count", op_count, c0 + CNT_W'(1));
      chk("bp_done_state", {busy, rsp_valid, req_ready}, {1'b0, 1'b0, 2'b10});
      @(posedge clk); #1 req_valid[1] = 1'b0;
      espera_rsp("bp_next", 1'b1, 16'h0038, 1'b0, lat);
      espera_ocioso();

      // signed overflow and multiply truncation
`ifdef ULA_SATURA_EN
      envia(0, 16'h7FFF, 16'h0001, 1'b0);
      espera_rsp("ovf_pos", 1'b0, 16'h7FFF, 1'b1, lat);
      envia(1, 16'h8000, 16'hFFFF, 1'b0);
      espera_rsp("ovf_neg", 1'b1, 16'h8000, 1'b1, lat);
`else
      envia(0, 16'h7FFF, 16'h0001, 1'b0);
      espera_rsp("ovf_pos", 1'b0, 16'h8000, 1'b1, lat);
      envia(1, 16'h8000, 16'hFFFF, 1'b0);
      espera_rsp("ovf_neg", 1'b1, 16'h7FFF, 1'b1, lat);
`endif
      envia(0, 16'h0100, 16'h0100, 1'b1);
      espera_rsp("mul_trunc", 1'b0, 16'h0000, 1'b0, lat);
      espera_ocioso();

      // reset during EXECUTA
      envia(0, 16'h0001, 16'h0002, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_ovf, busy},
          {2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
      chk("midrst_ula", {ula_sel, ula_a, ula_b}, '0);
      chk("midrst_count", op_count, 16'h0000);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk("midrst_no_rsp", rsp_valid, 1'b0);
      end
      @(posedge clk); #1;
      req_a0 = 16'h0002; req_b0 = 16'h0002; req_sel0 = 1'b0;
      req_a1 = 16'h0003; req_b1 = 16'h0003; req_sel1 = 1'b1;
      req_valid = 2'b11;
      @(negedge clk); #1;
      chk("midrst_tie", req_ready, 2'b01);
      drena(0);
      espera_ocioso();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
